// File: rtl/matrix_accel_sequencer.sv
// ---------------------------------------------------------------------------
// matrix_accel_sequencer
//
// Front-end job sequencer for the matrix accelerator. It collects a stream of
// (multiplier, multiplicand) operand pairs into KERNEL_SIZE*KERNEL_SIZE lanes
// and pulses the per-lane start vector for one cycle. It then waits for the
// accelerator's accumulated-ready flag, captures the signed accumulation and
// returns it on a valid/ready result stream. A new job is not accepted until
// the previous result has been handed off.
//
// Optional build macro: SEQ_TIMEOUT_EN
//   defined   - a WAIT watchdog aborts after TIMEOUT_CYCLES cycles, sets the
//               sticky err_timeout flag and emits a zero result.
//   undefined - WAIT holds until finalReady; err_timeout is tied low.
//
// Ports:
//   Clk, Rst            clock (rising edge), asynchronous active-low reset
//   s_valid/s_ready     operand pair handshake
//   s_data              [W-1:0] multiplier, [2W-1:W] multiplicand
//   s_last              final pair of the job (may end the job early)
//   multiplier_input    lane n at [n*W +: W]
//   multiplicand_input  lane n at [n*W +: W]
//   mStart              per-lane start, all ones for one cycle
//   finalReady          accelerator result ready (registered, may be stale)
//   finalAccumulate     signed accumulated result
//   m_valid/m_ready     result handshake
//   m_data              captured result, bit-exact copy of finalAccumulate
//   busy                low only when idle in LOAD with no lanes filled
//   job_count           completed results, wraps at 16 bits
//   err_timeout         sticky WAIT timeout flag
// ---------------------------------------------------------------------------
module matrix_accel_sequencer #(
    parameter int DATA_WIDTH     = 32,
    parameter int KERNEL_SIZE    = 3,
    parameter int AXI_BUS_WIDTH  = 32,
    parameter int MIN_LATENCY    = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                                             Clk,
    input  logic                                             Rst,
    input  logic                                             s_valid,
    output logic                                             s_ready,
    input  logic [2*AXI_BUS_WIDTH-1:0]                       s_data,
    input  logic                                             s_last,
    output logic [KERNEL_SIZE*KERNEL_SIZE*AXI_BUS_WIDTH-1:0] multiplier_input,
    output logic [KERNEL_SIZE*KERNEL_SIZE*AXI_BUS_WIDTH-1:0] multiplicand_input,
    output logic [KERNEL_SIZE*KERNEL_SIZE-1:0]               mStart,
    input  logic                                             finalReady,
    input  logic signed [AXI_BUS_WIDTH-1:0]                  finalAccumulate,
    output logic                                             m_valid,
    input  logic                                             m_ready,
    output logic signed [AXI_BUS_WIDTH-1:0]                  m_data,
    output logic                                             busy,
    output logic [15:0]                                      job_count,
    output logic                                             err_timeout
);

    localparam int N     = KERNEL_SIZE * KERNEL_SIZE;
    localparam int W     = AXI_BUS_WIDTH;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + MIN_LATENCY + 2);
    // The accelerator consumes DATA_WIDTH bits per lane; anything above that
    // on the bus is zeroed so lanes never carry stray upper bits.
    localparam int OP_W  = (DATA_WIDTH < W) ? DATA_WIDTH : W;

    typedef enum logic [1:0] {
        S_LOAD   = 2'd0,
        S_START  = 2'd1,
        S_WAIT   = 2'd2,
        S_OUTPUT = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [N*W-1:0]      mult_q, mult_d;
    logic [N*W-1:0]      mcand_q, mcand_d;
    logic                s_ready_q, s_ready_d;
    logic signed [W-1:0] m_data_q, m_data_d;
    logic [15:0]         job_count_q, job_count_d;
    logic [CNT_W-1:0]    wait_cnt_q, wait_cnt_d;
    logic                accept;
    logic                ready_qual;
`ifdef SEQ_TIMEOUT_EN
    logic                err_q, err_d;
`endif

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        mult_d      = mult_q;
        mcand_d     = mcand_q;
        m_data_d    = m_data_q;
        job_count_d = job_count_q;
        wait_cnt_d  = wait_cnt_q;
`ifdef SEQ_TIMEOUT_EN
        err_d       = err_q;
`endif
        accept      = (state_q == S_LOAD) && s_valid && s_ready_q;
        // finalReady is registered inside the accelerator and can still show
        // the previous job's result for the first MIN_LATENCY WAIT cycles.
        ready_qual  = (wait_cnt_q >= CNT_W'(MIN_LATENCY)) && finalReady;

        case (state_q)
            S_LOAD: begin
                if (accept) begin
                    for (int n = 0; n < N; n++) begin
                        if (idx_q == IDX_W'(n)) begin
                            mult_d[n*W +: W]  = W'(s_data[OP_W-1:0]);
                            mcand_d[n*W +: W] = W'(s_data[W +: OP_W]);
                        end
                    end
                    if (s_last || (idx_q == IDX_W'(N - 1))) begin
                        idx_d   = '0;
                        state_d = S_START;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            S_START: begin
                wait_cnt_d = '0;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                if (ready_qual) begin
                    m_data_d = finalAccumulate;
                    state_d  = S_OUTPUT;
`ifdef SEQ_TIMEOUT_EN
                end else if (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    m_data_d = '0;
                    err_d    = 1'b1;
                    state_d  = S_OUTPUT;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
`else
                end else if (wait_cnt_q < CNT_W'(MIN_LATENCY)) begin
                    // Counter only needs to reach MIN_LATENCY; it then holds.
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
`endif
            end
            S_OUTPUT: begin
                if (m_ready) begin
                    job_count_d = job_count_q + 16'd1;
                    mult_d      = '0;
                    mcand_d     = '0;
                    state_d     = S_LOAD;
                end
            end
            default: state_d = S_LOAD;
        endcase

        // Registered so s_ready stays low for the first cycle after reset.
        s_ready_d = (state_d == S_LOAD);
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q     <= S_LOAD;
            idx_q       <= '0;
            mult_q      <= '0;
            mcand_q     <= '0;
            s_ready_q   <= 1'b0;
            m_data_q    <= '0;
            job_count_q <= '0;
            wait_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            mult_q      <= mult_d;
            mcand_q     <= mcand_d;
            s_ready_q   <= s_ready_d;
            m_data_q    <= m_data_d;
            job_count_q <= job_count_d;
            wait_cnt_q  <= wait_cnt_d;
        end
    end

`ifdef SEQ_TIMEOUT_EN
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
    assign err_timeout = err_q;
`else
    assign err_timeout = 1'b0;
`endif

    assign s_ready            = s_ready_q;
    assign multiplier_input   = mult_q;
    assign multiplicand_input = mcand_q;
    assign mStart             = {N{state_q == S_START}};
    assign m_valid            = (state_q == S_OUTPUT);
    assign m_data             = m_data_q;
    assign job_count          = job_count_q;
    assign busy               = !((state_q == S_LOAD) && (idx_q == '0));

endmodule

// File: tb/tb_matrix_accel_sequencer.sv
module tb_matrix_accel_sequencer;

    localparam int N  = 9;
    localparam int W  = 32;
    localparam int TO = 16;

    logic                Clk = 1'b0;
    logic                Rst = 1'b0;
    logic                s_valid = 1'b0;
    logic                s_ready;
    logic [2*W-1:0]      s_data = '0;
    logic                s_last = 1'b0;
    logic [N*W-1:0]      multiplier_input;
    logic [N*W-1:0]      multiplicand_input;
    logic [N-1:0]        mStart;
    logic                finalReady;
    logic signed [W-1:0] finalAccumulate;
    logic                m_valid;
    logic                m_ready = 1'b0;
    logic signed [W-1:0] m_data;
    logic                busy;
    logic [15:0]         job_count;
    logic                err_timeout;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_jobs = 0;

    always #5 Clk = ~Clk;

    matrix_accel_sequencer #(
        .DATA_WIDTH(32), .KERNEL_SIZE(3), .AXI_BUS_WIDTH(W),
        .MIN_LATENCY(2), .TIMEOUT_CYCLES(TO)
    ) dut (
        .Clk(Clk), .Rst(Rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .multiplier_input(multiplier_input), .multiplicand_input(multiplicand_input),
        .mStart(mStart), .finalReady(finalReady), .finalAccumulate(finalAccumulate),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .busy(busy), .job_count(job_count), .err_timeout(err_timeout)
    );

    // Accelerator model: latches the lane dot product on mStart and raises
    // finalReady acc_delay+1 cycles after the start cycle. finalReady then
    // stays high (stale) until the next start.
    logic         acc_force = 1'b0;
    logic         acc_dead  = 1'b0;
    int           acc_delay = 2;
    int           acc_cd    = 0;
    logic         acc_rdy   = 1'b0;
    logic [W-1:0] acc_pend  = '0;
    logic [W-1:0] acc_val   = '0;

    assign finalReady      = acc_force | acc_rdy;
    assign finalAccumulate = acc_val;

    function automatic logic [W-1:0] lane_dot();
        logic [W-1:0] s = '0;
        for (int n = 0; n < N; n++)
            s = s + multiplier_input[n*W +: W] * multiplicand_input[n*W +: W];
        return s;
    endfunction

    always @(posedge Clk) begin
        if (mStart != '0) begin
            acc_pend <= lane_dot();
            acc_cd   <= acc_delay;
            acc_rdy  <= 1'b0;
        end else if (acc_cd != 0) begin
            if (acc_cd == 1 && !acc_dead) begin
                acc_rdy <= 1'b1;
                acc_val <= acc_pend;
            end
            acc_cd <= acc_cd - 1;
        end
    end

    // Output monitor, sampled just after each rising edge.
    int         cyc = 0;
    int         start_pulses = 0;
    int         start_cyc = 0;
    int         valid_rises = 0;
    int         valid_rise_cyc = 0;
    int         valid_cycles = 0;
    logic [N-1:0] start_val = '0;
    logic       prev_valid = 1'b0;

    always @(posedge Clk) begin
        #1;
        cyc++;
        if (mStart != '0) begin
            start_pulses++;
            start_val = mStart;
            start_cyc = cyc;
        end
        if (m_valid) valid_cycles++;
        if (m_valid && !prev_valid) begin
            valid_rises++;
            valid_rise_cyc = cyc;
        end
        prev_valid = m_valid;
    end

    // Job stimulus and reference model.
    logic [W-1:0] ja [N];
    logic [W-1:0] jb [N];

    function automatic logic [W-1:0] ref_result(input int nb);
        longint acc = 0;
        for (int k = 0; k < nb; k++)
            acc += longint'($signed(ja[k])) * longint'($signed(jb[k]));
        return W'(acc);
    endfunction

    function automatic logic [N*W-1:0] exp_lanes(input bit cand, input int nb);
        logic [N*W-1:0] v = '0;
        for (int k = 0; k < nb; k++) v[k*W +: W] = cand ? jb[k] : ja[k];
        return v;
    endfunction

    task automatic randomize_job();
        for (int k = 0; k < N; k++) begin
            ja[k] = $urandom;
            jb[k] = $urandom;
        end
    endtask

    task automatic send_job(input int nb, input bit last_flag, output bit ok);
        int  guard;
        bit  took;
        ok = 1'b1;
        for (int k = 0; k < nb; k++) begin
            guard   = 0;
            took    = 1'b0;
            s_valid = 1'b1;
            s_data  = {jb[k], ja[k]};
            s_last  = last_flag && (k == nb - 1);
            while (!took && ok) begin
                took = s_ready;
                @(negedge Clk);
                guard++;
                if (!took && guard > 50) ok = 1'b0;
            end
            if (!ok) break;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = '0;
    endtask

    task automatic wait_valid(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (m_valid) begin
                ok = 1'b1;
                break;
            end
            @(negedge Clk);
        end
    endtask

    task automatic handshake(input int delay);
        for (int i = 0; i < delay; i++) @(negedge Clk);
        m_ready = 1'b1;
        @(negedge Clk);
        m_ready = 1'b0;
    endtask

    task automatic pulse_reset();
        #2 Rst = 1'b0;
        #1;
        @(negedge Clk);
        Rst = 1'b1;
        @(negedge Clk);
        exp_jobs = 0;
    endtask

    task automatic test_reset_init();
        @(negedge Clk);
        n_checks++;
        if ({s_ready, m_valid, mStart, job_count, err_timeout, busy} !== '0) begin
            n_fail++;
            $display("FAIL init_outputs: got s_ready=%b m_valid=%b mStart=%h job_count=%0d err=%b busy=%b, expected all 0",
                     s_ready, m_valid, mStart, job_count, err_timeout, busy);
        end
        Rst = 1'b1;
        #1;
        n_checks++;
        if (s_ready !== 1'b0) begin n_fail++; $display("FAIL init_ready_at_release: got %b expected 0", s_ready); end
        @(negedge Clk);
        n_checks++;
        if (s_ready !== 1'b1) begin n_fail++; $display("FAIL init_ready_after: got %b expected 1", s_ready); end
    endtask

    task automatic test_full_job();
        bit ok;
        for (int k = 0; k < N; k++) begin ja[k] = W'(k + 1); jb[k] = 2; end
        acc_delay = 2; start_pulses = 0;
        send_job(9, 1'b0, ok);
        wait_valid(50, ok);
        n_checks++;
        if (ok !== 1'b1) begin n_fail++; $display("FAIL full_wait: got timeout expected m_valid"); end
        n_checks++;
        if (start_pulses !== 1 || start_val !== 9'h1FF) begin
            n_fail++; $display("FAIL full_mstart: got %0d cycles value %h expected 1 cycle value 1ff", start_pulses, start_val);
        end
        n_checks++;
        if (multiplier_input[8*W +: W] !== 32'd9) begin
            n_fail++; $display("FAIL full_lane8: got %0d expected 9", multiplier_input[8*W +: W]);
        end
        n_checks++;
        if (m_data !== 32'sd90) begin n_fail++; $display("FAIL full_m_data: got %0d expected 90", m_data); end
        n_checks++;
        if (valid_rise_cyc - start_cyc !== 4) begin
            n_fail++; $display("FAIL full_latency: got %0d expected 4", valid_rise_cyc - start_cyc);
        end
        handshake(0);
        exp_jobs++;
        n_checks++;
        if (job_count !== 16'(exp_jobs) || m_valid !== 1'b0 || s_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL full_after_hs: got jobs=%0d m_valid=%b s_ready=%b busy=%b expected %0d 0 1 0",
                               job_count, m_valid, s_ready, busy, exp_jobs);
        end
        n_checks++;
        if (multiplier_input !== '0 || multiplicand_input !== '0) begin
            n_fail++; $display("FAIL full_lanes_cleared: got %h expected 0", multiplier_input);
        end
        // Random full job with a redundant s_last on lane 8.
        randomize_job();
        send_job(9, 1'b1, ok);
        wait_valid(50, ok);
        n_checks++;
        if (multiplier_input !== exp_lanes(0, 9) || multiplicand_input !== exp_lanes(1, 9)) begin
            n_fail++; $display("FAIL rand_lanes: got %h expected %h", multiplier_input, exp_lanes(0, 9));
        end
        n_checks++;
        if (m_data !== ref_result(9)) begin n_fail++; $display("FAIL rand_m_data: got %h expected %h", m_data, ref_result(9)); end
        handshake(1);
        exp_jobs++;
        n_checks++;
        if (job_count !== 16'(exp_jobs)) begin n_fail++; $display("FAIL rand_jobs: got %0d expected %0d", job_count, exp_jobs); end
    endtask

    task automatic test_early_last();
        bit ok;
        int nb;
        for (int k = 0; k < N; k++) begin ja[k] = 5; jb[k] = 5; end
        start_pulses = 0;
        send_job(4, 1'b1, ok);
        wait_valid(50, ok);
        n_checks++;
        if (multiplier_input !== exp_lanes(0, 4) || multiplicand_input !== exp_lanes(1, 4)) begin
            n_fail++; $display("FAIL early_lanes: got %h expected %h", multiplier_input, exp_lanes(0, 4));
        end
        n_checks++;
        if (m_data !== 32'sd100) begin n_fail++; $display("FAIL early_m_data: got %0d expected 100", m_data); end
        n_checks++;
        if (start_pulses !== 1) begin n_fail++; $display("FAIL early_mstart: got %0d cycles expected 1", start_pulses); end
        handshake(2);
        exp_jobs++;
        for (int j = 0; j < 3; j++) begin
            randomize_job();
            nb = $urandom_range(1, 8);
            send_job(nb, 1'b1, ok);
            wait_valid(50, ok);
            n_checks++;
            if (multiplier_input !== exp_lanes(0, nb) || m_data !== ref_result(nb)) begin
                n_fail++; $display("FAIL early_rand nb=%0d: got m_data %h expected %h", nb, m_data, ref_result(nb));
            end
            handshake(0);
            exp_jobs++;
        end
        n_checks++;
        if (job_count !== 16'(exp_jobs)) begin n_fail++; $display("FAIL early_jobs: got %0d expected %0d", job_count, exp_jobs); end
    endtask

    task automatic test_reset();
        bit ok;
        randomize_job();
        send_job(3, 1'b0, ok);
        n_checks++;
        if (busy !== 1'b1 || job_count === 16'd0) begin
            n_fail++; $display("FAIL reset_pre: got busy=%b jobs=%0d expected busy 1 jobs nonzero", busy, job_count);
        end
        #2 Rst = 1'b0;
        #1;
        n_checks++;
        if ({s_ready, m_valid, mStart, job_count, err_timeout, busy} !== '0) begin
            n_fail++;
            $display("FAIL reset_async: got s_ready=%b m_valid=%b mStart=%h job_count=%0d err=%b busy=%b, expected all 0",
                     s_ready, m_valid, mStart, job_count, err_timeout, busy);
        end
        n_checks++;
        if (multiplier_input !== '0 || multiplicand_input !== '0) begin
            n_fail++; $display("FAIL reset_lanes: got %h expected 0", multiplier_input);
        end
        @(negedge Clk);
        Rst = 1'b1;
        #1;
        n_checks++;
        if (s_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready_at_release: got %b expected 0", s_ready); end
        @(negedge Clk);
        exp_jobs = 0;
        n_checks++;
        if (s_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready_after: got %b expected 1", s_ready); end
    endtask

    task automatic test_min_latency_backpressure();
        bit ok;
        logic [W-1:0] exp;
        randomize_job();
        exp = ref_result(9);
        acc_force = 1'b1; acc_delay = 2;
        send_job(9, 1'b0, ok);
        // Offer junk operands while the job is in flight; none may be taken.
        s_valid = 1'b1;
        s_data  = {$urandom, $urandom};
        wait_valid(50, ok);
        n_checks++;
        if (valid_rise_cyc - start_cyc !== 4) begin
            n_fail++; $display("FAIL minlat_capture: got %0d expected 4", valid_rise_cyc - start_cyc);
        end
        n_checks++;
        if (m_data !== exp) begin n_fail++; $display("FAIL minlat_m_data: got %h expected %h", m_data, exp); end
        for (int i = 0; i < 10; i++) begin
            @(negedge Clk);
            n_checks++;
            if ({m_valid, s_ready, m_data} !== {1'b1, 1'b0, exp}) begin
                n_fail++; $display("FAIL hold_%0d: got valid=%b ready=%b data=%h expected 1 0 %h", i, m_valid, s_ready, m_data, exp);
            end
        end
        s_valid = 1'b0;
        handshake(0);
        exp_jobs++;
        n_checks++;
        if (job_count !== 16'(exp_jobs) || m_valid !== 1'b0 || busy !== 1'b0 || multiplier_input !== '0) begin
            n_fail++; $display("FAIL hs_once: got jobs=%0d m_valid=%b busy=%b expected %0d 0 0", job_count, m_valid, busy, exp_jobs);
        end
        @(negedge Clk);
        @(negedge Clk);
        n_checks++;
        if (job_count !== 16'(exp_jobs)) begin n_fail++; $display("FAIL hs_no_repeat: got %0d expected %0d", job_count, exp_jobs); end
        acc_force = 1'b0;
    endtask

    task automatic test_back_to_back();
        bit ok;
        int nb;
        for (int j = 0; j < 6; j++) begin
            randomize_job();
            nb = $urandom_range(1, 9);
            acc_delay = $urandom_range(1, 6);
            start_pulses = 0;
            send_job(nb, (nb < N) ? 1'b1 : 1'($urandom_range(0, 1)), ok);
            wait_valid(60, ok);
            n_checks++;
            if (ok !== 1'b1 || m_data !== ref_result(nb) || start_pulses !== 1) begin
                n_fail++; $display("FAIL b2b_%0d: got data %h pulses %0d expected %h 1", j, m_data, start_pulses, ref_result(nb));
            end
            handshake($urandom_range(0, 3));
            exp_jobs++;
            n_checks++;
            if (job_count !== 16'(exp_jobs)) begin n_fail++; $display("FAIL b2b_jobs_%0d: got %0d expected %0d", j, job_count, exp_jobs); end
        end
    endtask

    task automatic test_reset_mid_wait();
        bit ok;
        randomize_job();
        acc_dead = 1'b1;
        send_job(9, 1'b0, ok);
        repeat (3) @(negedge Clk);
        n_checks++;
        if (busy !== 1'b1 || m_valid !== 1'b0) begin n_fail++; $display("FAIL midwait_pre: got busy=%b m_valid=%b expected 1 0", busy, m_valid); end
        pulse_reset();
        acc_dead = 1'b0; acc_delay = 3;
        valid_rises = 0;
        n_checks++;
        if (job_count !== 16'd0 || m_valid !== 1'b0) begin n_fail++; $display("FAIL midwait_cleared: got jobs=%0d m_valid=%b expected 0 0", job_count, m_valid); end
        for (int k = 0; k < N; k++) begin ja[k] = 1; jb[k] = 1; end
        send_job(9, 1'b0, ok);
        wait_valid(50, ok);
        n_checks++;
        if (m_data !== 32'sd9 || valid_rises !== 1) begin
            n_fail++; $display("FAIL midwait_result: got data %0d rises %0d expected 9 1", m_data, valid_rises);
        end
        handshake(0);
        exp_jobs++;
        n_checks++;
        if (job_count !== 16'd1) begin n_fail++; $display("FAIL midwait_jobs: got %0d expected 1", job_count); end
    endtask

    task automatic test_timeout();
        bit ok;
        randomize_job();
        acc_dead = 1'b1;
        send_job(9, 1'b0, ok);
`ifdef SEQ_TIMEOUT_EN
        wait_valid(60, ok);
        n_checks++;
        if (ok !== 1'b1 || valid_rise_cyc - start_cyc !== TO + 1) begin
            n_fail++; $display("FAIL timeout_latency: got %0d expected %0d", valid_rise_cyc - start_cyc, TO + 1);
        end
        n_checks++;
        if (err_timeout !== 1'b1 || m_data !== '0) begin
            n_fail++; $display("FAIL timeout_result: got err=%b data=%h expected 1 0", err_timeout, m_data);
        end
        handshake(1);
        exp_jobs++;
        n_checks++;
        if (job_count !== 16'(exp_jobs) || err_timeout !== 1'b1 || m_valid !== 1'b0) begin
            n_fail++; $display("FAIL timeout_after: got jobs=%0d err=%b m_valid=%b expected %0d 1 0", job_count, err_timeout, m_valid, exp_jobs);
        end
        pulse_reset();
        n_checks++;
        if (err_timeout !== 1'b0) begin n_fail++; $display("FAIL timeout_cleared: got %b expected 0", err_timeout); end
`else
        valid_cycles = 0;
        repeat (200) @(negedge Clk);
        n_checks++;
        if (valid_cycles !== 0 || m_valid !== 1'b0 || busy !== 1'b1 || err_timeout !== 1'b0) begin
            n_fail++; $display("FAIL no_timeout: got valid_cycles=%0d m_valid=%b busy=%b err=%b expected 0 0 1 0",
                               valid_cycles, m_valid, busy, err_timeout);
        end
        pulse_reset();
        n_checks++;
        if (s_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL no_timeout_recover: got s_ready=%b busy=%b expected 1 0", s_ready, busy); end
`endif
        acc_dead = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset_init();
        test_full_job();
        test_early_last();
        test_reset();
        test_min_latency_backpressure();
        test_back_to_back();
        test_reset_mid_wait();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
